seg_frame_display: RTL and testbench

Downstream consumer of the anode rotation counter in the FPU result display path. The block takes an 8-bit result (two hex digits) plus an error flag through a valid/ready handshake. It swaps the value onto the display only at frame boundaries, so a digit pair never tears. It drives active-low seven-segment cathodes in step with the counter's digit slots, with ghost-suppression blanking and blinking on error.

---
 rtl/seg_frame_display.sv | 125 ++++++++++++
 tb/tb_seg_frame_display.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_frame_display.sv
// Two-digit hex seven-segment driver: frame-aligned value swap, slot-start blanking
// and error blink, slaved to an external 5-bit anode rotation counter.
module seg_frame_display #(
    parameter int unsigned BLANK_CYCLES = 2,
    parameter int unsigned BLINK_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] count,
    input  logic [7:0] data_in,
    input  logic       err_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;
    localparam int unsigned FCNT_LAST = 2 * BLINK_FRAMES - 1;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PENDING = 2'd1,
        SHOW    = 2'd2
    } state_t;

    state_t            state;
    logic [7:0]        shadow;
    logic              shadow_err;
    logic [7:0]        disp;
    logic              disp_err;
    logic [FCNT_W-1:0] fcnt;

    logic       boundary;
    logic       blank;
    logic [3:0] nib;
    logic [6:0] seg_nxt;
    logic       dp_nxt;

    // Active-low {g,f,e,d,c,b,a} hex glyphs.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign data_ready = (state != PENDING);

    // Next display values from the sampled slot position; blanking hides the anode switch.
    always_comb begin
        boundary = (count == 5'h1F);
        blank    = (state == EMPTY)
                 || (count[3:0] == 4'd0)
                 || ({1'b0, count[3:0]} >= 5'(16 - BLANK_CYCLES))
                 || (disp_err && (fcnt >= FCNT_W'(BLINK_FRAMES)));
        nib      = count[4] ? disp[3:0] : disp[7:4];
        seg_nxt  = blank ? 7'h7F : hex7(nib);
        dp_nxt   = blank | ~(count[4] & disp_err);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= EMPTY;
            shadow     <= 8'h00;
            shadow_err <= 1'b0;
            disp       <= 8'h00;
            disp_err   <= 1'b0;
            fcnt       <= '0;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= boundary;
            seg        <= seg_nxt;
            dp         <= dp_nxt;

            // Blink phase restarts with every newly shown value.
            if (boundary) begin
                if (state == PENDING)
                    fcnt <= '0;
                else if (fcnt == FCNT_W'(FCNT_LAST))
                    fcnt <= '0;
                else
                    fcnt <= fcnt + FCNT_W'(1);
            end

            case (state)
                EMPTY, SHOW: begin
                    if (data_valid) begin
                        shadow     <= data_in;
                        shadow_err <= err_in;
                        state      <= PENDING;
                    end
                end
                PENDING: begin
                    if (boundary) begin
                        disp     <= shadow;
                        disp_err <= shadow_err;
                        state    <= SHOW;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_frame_display.sv
// Bench for seg_frame_display: directed scenarios plus random traffic, checked every
// cycle against a frame-level reference model of what the display should show.
module tb_seg_frame_display;

    localparam int BLANK = 2;
    localparam int BLINK = 8;

    logic       clk;
    logic       reset;
    logic [4:0] count;
    logic [7:0] data_in;
    logic       err_in;
    logic       data_valid;
    logic       data_ready;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int tests = 0;
    int fails = 0;

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model: what has been accepted, what is on display, frames since it appeared.
    bit         in_rst;
    bit         m_any;
    bit         m_pending;
    logic [7:0] m_shadow;
    bit         m_shadow_err;
    logic [7:0] m_disp;
    bit         m_disp_err;
    int         m_frames;
    int         m_acc;

    seg_frame_display #(.BLANK_CYCLES(BLANK), .BLINK_FRAMES(BLINK)) dut (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .data_in    (data_in),
        .err_in     (err_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_clear();
        m_any        = 0;
        m_pending    = 0;
        m_shadow     = 8'h00;
        m_shadow_err = 0;
        m_disp       = 8'h00;
        m_disp_err   = 0;
        m_frames     = 0;
    endtask

    // One clock: drive inputs, predict, clock, check outputs, advance the upstream counter.
    task automatic step(input logic v, input logic [7:0] d, input logic e);
        logic       bnd;
        logic       acc;
        logic       blank;
        logic [3:0] nib;
        logic [6:0] es;
        logic       edp;
        logic       etick;
        data_valid = v;
        data_in    = d;
        err_in     = e;
        bnd = (count == 5'h1F);
        if (in_rst) begin
            es    = 7'h7F;
            edp   = 1'b1;
            etick = 1'b0;
        end else begin
            acc   = v && !m_pending;
            blank = !m_any || (count[3:0] == 4'd0) || (int'(count[3:0]) >= 16 - BLANK)
                  || (m_disp_err && ((m_frames / BLINK) % 2 == 1));
            nib   = count[4] ? m_disp[3:0] : m_disp[7:4];
            es    = blank ? 7'h7F : hex_tab[nib];
            edp   = blank ? 1'b1 : !(count[4] && m_disp_err);
            etick = bnd;
            if (bnd && m_pending) begin
                m_disp     = m_shadow;
                m_disp_err = m_shadow_err;
                m_pending  = 0;
                m_frames   = 0;
            end else if (bnd) begin
                m_frames++;
            end
            if (acc) begin
                m_shadow     = d;
                m_shadow_err = e;
                m_pending    = 1;
                m_any        = 1;
                m_acc++;
            end
        end
        @(posedge clk);
        #1;
        chk("seg", {1'b0, seg}, {1'b0, es});
        chk("dp", {7'b0, dp}, {7'b0, edp});
        chk("frame_tick", {7'b0, frame_tick}, {7'b0, etick});
        chk("data_ready", {7'b0, data_ready}, {7'b0, (in_rst || !m_pending)});
        count = count - 5'd1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic run_to(input logic [4:0] c);
        for (int i = 0; i < 32; i++) begin
            if (count == c) break;
            step(1'b0, 8'h00, 1'b0);
        end
    endtask

    // Hold an offer until the model says it was taken (bounded).
    task automatic offer(input logic [7:0] d, input logic e);
        int n;
        n = m_acc;
        for (int i = 0; i < 80; i++) begin
            step(1'b1, d, e);
            if (m_acc != n) break;
        end
        chk("offer_taken", 8'(m_acc - n), 8'd1);
    endtask

    initial begin
        reset      = 1'b0;
        in_rst     = 1;
        count      = 5'd9;
        data_in    = 8'h00;
        err_in     = 1'b0;
        data_valid = 1'b0;
        m_acc      = 0;
        model_clear();

        // Reset held with the counter running.
        idle(40);
        reset  = 1'b1;
        in_rst = 0;
        idle(70);

        // 3A offered mid-frame, a second value during PENDING is ignored.
        run_to(5'b10100);
        step(1'b1, 8'h3A, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        chk("ready_pending", {7'b0, data_ready}, 8'd0);
        idle(50);
        offer(8'h55, 1'b0);
        idle(70);

        // Offer landing exactly on a boundary edge while showing.
        run_to(5'h1F);
        step(1'b1, 8'h12, 1'b0);
        idle(70);

        // Error value: blink visible/dark over 16-frame periods.
        offer(8'h00, 1'b1);
        idle(20 * 32);

        // Asynchronous reset while PENDING.
        offer(8'hC7, 1'b0);
        #2;
        reset  = 1'b0;
        in_rst = 1;
        model_clear();
        #1;
        chk("arst_seg", {1'b0, seg}, 8'h7F);
        chk("arst_dp", {7'b0, dp}, 8'd1);
        chk("arst_ready", {7'b0, data_ready}, 8'd1);
        chk("arst_tick", {7'b0, frame_tick}, 8'd0);
        idle(10);
        reset  = 1'b1;
        in_rst = 0;
        idle(40);
        offer(8'hE4, 1'b1);
        idle(70);

        // Random traffic with occasional upstream counter jumps.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) count = 5'($urandom_range(0, 31));
            step(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 2) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
